// File: rtl/vga_cmd_queue_pkg.sv
// Opcode table, register map, status bit positions and assembler states
// shared by the VGA command queue.
package vga_cmd_queue_pkg;

    localparam logic [7:0] OP_TEXT_WRITE    = 8'h00;
    localparam logic [7:0] OP_TEXT_POSITION = 8'h01;
    localparam logic [7:0] OP_TEXT_CLEAR    = 8'h02;
    localparam logic [7:0] OP_WRITE_PIXEL   = 8'h10;

    localparam logic [3:0] ADDR_MODE   = 4'h0;
    localparam logic [3:0] ADDR_OPCODE = 4'h1;
    localparam logic [3:0] ADDR_ARG0   = 4'h2;
    localparam logic [3:0] ADDR_STATUS = 4'hF;

    localparam int unsigned SB_BUSY   = 0;
    localparam int unsigned SB_FULL   = 1;
    localparam int unsigned SB_ERR    = 2;
    localparam int unsigned SB_OVF    = 3;
    localparam int unsigned SB_OCC_LO = 4;
    localparam int unsigned SB_READY  = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISCARD
    } asm_state_e;

    // Argument count for an opcode; 0 marks an unknown opcode.
    function automatic logic [3:0] op_argc(input logic [7:0] op);
        case (op)
            OP_TEXT_WRITE:    op_argc = 4'd2;
            OP_TEXT_POSITION: op_argc = 4'd2;
            OP_TEXT_CLEAR:    op_argc = 4'd1;
            OP_WRITE_PIXEL:   op_argc = 4'd1;
            default:          op_argc = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/vga_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Simultaneous push and pop are both honoured, including when full.
module vga_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);
    // Head is forced to zero when empty so the consumer never sees stale data.
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_cmd_queue.sv
// Register-write command assembler feeding a command FIFO, with mode and
// status registers for the VGA instruction executor.
module vga_cmd_queue
    import vga_cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_ARGS = 4
) (
    input  logic                    clk_25mhz,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [3:0]              wr_addr,
    input  logic [7:0]              wr_data,
    input  logic                    rd_en,
    input  logic [3:0]              rd_addr,
    output logic [7:0]              rd_data,
    output logic [7:0]              mode,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [7:0]              cmd_opcode,
    output logic [8*MAX_ARGS-1:0]   cmd_args,
    output logic [3:0]              cmd_argc,
    input  logic                    exec_busy
);
    localparam int unsigned ARGS_W = 8 * MAX_ARGS;
    localparam int unsigned FIFO_W = 8 + ARGS_W + 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [3:0]  ADDR_ARG_LAST = 4'(1 + MAX_ARGS);

    asm_state_e                 r_state;
    asm_state_e                 w_state_nxt;
    logic [7:0]                 r_opcode;
    logic [3:0]                 r_argc;
    logic [MAX_ARGS-1:0][7:0]   r_args;
    logic [MAX_ARGS-1:0][7:0]   w_args_nxt;
    logic                       r_err;
    logic                       r_ovf;

    logic                       w_wr_op;
    logic                       w_wr_arg;
    logic                       w_wr_status;
    logic                       w_op_ok;
    logic                       w_trigger;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_err_set;
    logic                       w_ovf_set;
    logic [3:0]                 w_op_argc;
    logic [3:0]                 w_arg_idx;
    logic [CNT_W-1:0]           w_count;
    logic [FIFO_W-1:0]          w_push_data;
    logic [FIFO_W-1:0]          w_head;
    logic [2:0]                 w_occ_sat;
    logic [7:0]                 w_status;
    logic [7:0]                 w_rd_val;

    assign w_wr_op     = wr_en && (wr_addr == ADDR_OPCODE);
    assign w_wr_arg    = wr_en && (wr_addr >= ADDR_ARG0) && (wr_addr <= ADDR_ARG_LAST);
    assign w_wr_status = wr_en && (wr_addr == ADDR_STATUS);
    assign w_arg_idx   = wr_addr - ADDR_ARG0;
    assign w_op_argc   = op_argc(wr_data);
    assign w_op_ok     = (w_op_argc != 4'd0) && (32'(w_op_argc) <= MAX_ARGS);
    // Writing the last argument of the latched opcode completes the command.
    assign w_trigger   = (r_state == S_COLLECT) && w_wr_arg && (wr_addr == r_argc + 4'd1);

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_err_set   = 1'b0;
        if (w_wr_op) begin
            w_state_nxt = w_op_ok ? S_COLLECT : S_DISCARD;
            w_err_set   = !w_op_ok;
        end else if (w_trigger) begin
            w_state_nxt = S_IDLE;
            w_push      = 1'b1;
        end
    end

    always_comb begin
        w_args_nxt = r_args;
        for (int i = 0; i < int'(MAX_ARGS); i++) begin
            if (w_wr_arg && (w_arg_idx == 4'(i))) begin
                w_args_nxt[i] = wr_data;
            end
        end
    end

    assign w_push_data = {r_opcode, w_args_nxt, r_argc};
    assign cmd_valid   = !w_empty;
    assign w_pop       = cmd_valid && cmd_ready;
    assign w_ovf_set   = w_push && w_full && !w_pop;
    assign cmd_opcode  = w_head[FIFO_W-1 -: 8];
    assign cmd_args    = w_head[4 +: ARGS_W];
    assign cmd_argc    = w_head[3:0];

    vga_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_25mhz),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_occ_sat = (32'(w_count) > 32'd7) ? 3'd7 : 3'(w_count);
        w_status  = 8'h00;
        w_status[SB_READY]        = 1'b1;
        w_status[SB_OCC_LO +: 3]  = w_occ_sat;
        w_status[SB_OVF]          = r_ovf;
        w_status[SB_ERR]          = r_err;
        w_status[SB_FULL]         = w_full;
        w_status[SB_BUSY]         = !w_empty || exec_busy || (r_state == S_COLLECT);
    end

    always_comb begin
        w_rd_val = 8'h00;
        if (rd_addr == ADDR_MODE) begin
            w_rd_val = mode;
        end else if (rd_addr == ADDR_STATUS) begin
            w_rd_val = w_status;
        end else begin
            for (int i = 0; i < int'(MAX_ARGS); i++) begin
                if (rd_addr == 4'(i + 2)) begin
                    w_rd_val = r_args[i];
                end
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_opcode <= 8'h00;
            r_argc   <= 4'd0;
            r_args   <= '0;
            r_err    <= 1'b0;
            r_ovf    <= 1'b0;
            mode     <= 8'h00;
            rd_data  <= 8'h00;
        end else begin
            r_args <= w_args_nxt;
            if (w_wr_op) begin
                r_opcode <= wr_data;
                r_argc   <= w_op_argc;
            end
            if (wr_en && (wr_addr == ADDR_MODE)) begin
                mode <= wr_data;
            end
            if (rd_en) begin
                rd_data <= w_rd_val;
            end
            // Sticky flags: a set in the same cycle as a clear wins.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_wr_status && wr_data[SB_ERR]) begin
                r_err <= 1'b0;
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status && wr_data[SB_OVF]) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_cmd_queue.sv
// Self-checking bench for vga_cmd_queue: directed vector table, corner-case
// sequences and random traffic against a queue-based reference model.
module tb_vga_cmd_queue;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned MAX_ARGS = 4;
    localparam int unsigned AW       = 8 * MAX_ARGS;

    logic            clk_25mhz;
    logic            reset;
    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [7:0]      wr_data;
    logic            rd_en;
    logic [3:0]      rd_addr;
    logic [7:0]      rd_data;
    logic [7:0]      mode;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [7:0]      cmd_opcode;
    logic [AW-1:0]   cmd_args;
    logic [3:0]      cmd_argc;
    logic            exec_busy;

    vga_cmd_queue #(.DEPTH(DEPTH), .MAX_ARGS(MAX_ARGS)) dut (
        .clk_25mhz  (clk_25mhz),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .mode       (mode),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_args   (cmd_args),
        .cmd_argc   (cmd_argc),
        .exec_busy  (exec_busy)
    );

    initial clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [7:0]    op;
        logic [AW-1:0] args;
        logic [3:0]    argc;
    } cmd_t;

    int         m_state;   // 0 idle, 1 collecting, 2 discarding
    logic [7:0] m_mode;
    logic [7:0] m_rd;
    int         m_argc;
    logic [7:0] m_op;
    logic [7:0] m_args [MAX_ARGS];
    bit         m_err;
    bit         m_ovf;
    cmd_t       m_q [$];

    function automatic int spec_argc(input logic [7:0] op);
        case (op)
            8'h00, 8'h01: return 2;
            8'h02, 8'h10: return 1;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [7:0] model_status(input bit eb);
        logic [7:0] s;
        int occ;
        occ = (m_q.size() > 7) ? 7 : m_q.size();
        s = 8'h80;
        s[6:4] = 3'(occ);
        s[3] = m_ovf;
        s[2] = m_err;
        s[1] = (m_q.size() == DEPTH);
        s[0] = (m_q.size() > 0) || eb || (m_state == 1);
        return s;
    endfunction

    function automatic logic [7:0] model_read(input logic [3:0] a, input bit eb);
        int ai;
        ai = int'(a);
        if (ai == 0) return m_mode;
        if (ai == 15) return model_status(eb);
        if (ai >= 2 && ai <= 1 + MAX_ARGS) return m_args[ai - 2];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_state = 0; m_mode = 8'h00; m_rd = 8'h00; m_argc = 0; m_op = 8'h00;
        m_err = 0; m_ovf = 0;
        for (int i = 0; i < MAX_ARGS; i++) m_args[i] = 8'h00;
        m_q.delete();
    endtask

    task automatic model_update(input bit we, input logic [3:0] wa, input logic [7:0] wd,
                                input bit re, input logic [3:0] ra, input bit rdy, input bit eb);
        logic [7:0] rdv;
        bit pop;
        bit do_push;
        int pre;
        int ai;
        cmd_t c;
        rdv = model_read(ra, eb);
        pre = m_q.size();
        pop = (pre > 0) && rdy;
        do_push = 0;
        ai = int'(wa);
        if (we) begin
            if (ai == 0) m_mode = wd;
            else if (ai == 1) begin
                m_op = wd;
                m_argc = spec_argc(wd);
                if (m_argc != 0 && m_argc <= MAX_ARGS) m_state = 1;
                else begin m_err = 1; m_state = 2; end
            end else if (ai >= 2 && ai <= 1 + MAX_ARGS) begin
                m_args[ai - 2] = wd;
                if (m_state == 1 && ai == 1 + m_argc) begin do_push = 1; m_state = 0; end
            end else if (ai == 15) begin
                if (wd[2]) m_err = 0;
                if (wd[3]) m_ovf = 0;
            end
        end
        if (re) m_rd = rdv;
        if (pop) void'(m_q.pop_front());
        if (do_push) begin
            c.op = m_op;
            c.argc = 4'(m_argc);
            for (int i = 0; i < MAX_ARGS; i++) c.args[i*8 +: 8] = m_args[i];
            if (pre == DEPTH && !pop) m_ovf = 1;
            else m_q.push_back(c);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input bit rst, input bit we, input logic [3:0] wa, input logic [7:0] wd,
                        input bit re, input logic [3:0] ra, input bit rdy, input bit eb);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; cmd_ready = rdy; exec_busy = eb;
        @(posedge clk_25mhz);
        if (rst) model_reset();
        else model_update(we, wa, wd, re, ra, rdy, eb);
        @(negedge clk_25mhz);
        chk("cmd_valid", 64'(cmd_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("cmd_opcode", 64'(cmd_opcode), 64'(m_q[0].op));
            chk("cmd_args", 64'(cmd_args), 64'(m_q[0].args));
            chk("cmd_argc", 64'(cmd_argc), 64'(m_q[0].argc));
        end
        chk("mode", 64'(mode), 64'(m_mode));
        chk("rd_data", 64'(rd_data), 64'(m_rd));
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d, input bit rdy);
        step(1'b0, 1'b1, a, d, 1'b0, 4'h0, rdy, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       re;
        logic [3:0] ra;
        logic       rdy;
        logic [7:0] e_rd;
        logic       e_valid;
        logic [7:0] e_op;
        logic [3:0] e_argc;
        logic [15:0] e_args;
    } vec_t;

    vec_t vt [16];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops;
        int thr;
        bit we, re, rdy, eb, rst;
        logic [3:0] wa, ra;
        logic [7:0] wd;

        vt[0]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 8'h80, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[1]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[2]  = '{1'b1, 4'h1, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[3]  = '{1'b1, 4'h2, 8'h0F, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[4]  = '{1'b1, 4'h3, 8'h48, 1'b0, 4'h0, 1'b0, 8'h00, 1'b1, 8'h00, 4'd2, 16'h480F};
        vt[5]  = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 8'h91, 1'b1, 8'h00, 4'd2, 16'h480F};
        vt[6]  = '{1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h91, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[7]  = '{1'b1, 4'h1, 8'h02, 1'b0, 4'h0, 1'b0, 8'h91, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[8]  = '{1'b1, 4'h2, 8'h07, 1'b0, 4'h0, 1'b0, 8'h91, 1'b1, 8'h02, 4'd1, 16'h4807};
        vt[9]  = '{1'b1, 4'h3, 8'h55, 1'b0, 4'h0, 1'b1, 8'h91, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[10] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 8'h80, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[11] = '{1'b1, 4'h1, 8'hFF, 1'b0, 4'h0, 1'b0, 8'h80, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[12] = '{1'b1, 4'h2, 8'h00, 1'b0, 4'h0, 1'b0, 8'h80, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[13] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 8'h84, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[14] = '{1'b1, 4'hF, 8'h04, 1'b0, 4'h0, 1'b0, 8'h84, 1'b0, 8'h00, 4'd0, 16'h0000};
        vt[15] = '{1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 8'h80, 1'b0, 8'h00, 4'd0, 16'h0000};

        reset = 1'b1; wr_en = 1'b0; wr_addr = 4'h0; wr_data = 8'h00;
        rd_en = 1'b0; rd_addr = 4'h0; cmd_ready = 1'b0; exec_busy = 1'b0;
        model_reset();
        @(negedge clk_25mhz);
        do_reset();
        chk("reset_opcode", 64'(cmd_opcode), 64'h0);
        chk("reset_args", 64'(cmd_args), 64'h0);
        chk("reset_argc", 64'(cmd_argc), 64'h0);
        chk("reset_rd_data", 64'(rd_data), 64'h0);

        for (int i = 0; i < 16; i++) begin
            step(1'b0, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra, vt[i].rdy, 1'b0);
            chk($sformatf("vec%0d_rd", i), 64'(rd_data), 64'(vt[i].e_rd));
            chk($sformatf("vec%0d_valid", i), 64'(cmd_valid), 64'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_op", i), 64'(cmd_opcode), 64'(vt[i].e_op));
                chk($sformatf("vec%0d_argc", i), 64'(cmd_argc), 64'(vt[i].e_argc));
                chk($sformatf("vec%0d_args", i), 64'(cmd_args[15:0]), 64'(vt[i].e_args));
            end
        end

        // Overflow: DEPTH+1 TextClears with the consumer stalled.
        do_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            wr(4'h1, 8'h02, 1'b0);
            wr(4'h2, 8'(k), 1'b0);
        end
        rd(4'hF);
        chk("ovf_status", 64'(rd_data), 64'hFB);
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cmd_valid) break;
            chk("ovf_pop_arg", 64'(cmd_args[7:0]), 64'(pops));
            step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);
            pops++;
        end
        chk("ovf_pop_count", 64'(pops), 64'd8);
        wr(4'hF, 8'h08, 1'b0);
        rd(4'hF);
        chk("ovf_cleared", 64'(rd_data), 64'h80);

        // exec_busy alone raises busy; then a TextPosition queues normally.
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 4'hF, 1'b0, 1'b1);
        chk("exec_busy_status", 64'(rd_data), 64'h81);
        wr(4'h1, 8'h01, 1'b0);
        wr(4'h2, 8'hAA, 1'b0);
        wr(4'h3, 8'hBB, 1'b0);
        chk("tpos_valid", 64'(cmd_valid), 64'h1);
        chk("tpos_op", 64'(cmd_opcode), 64'h01);
        chk("tpos_args", 64'(cmd_args[15:0]), 64'hBBAA);
        chk("tpos_argc", 64'(cmd_argc), 64'h2);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0);

        // Push and pop in the same cycle at occupancy 3.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            wr(4'h1, 8'h02, 1'b0);
            wr(4'h2, 8'(8'h20 + k), 1'b0);
        end
        wr(4'h1, 8'h02, 1'b0);
        wr(4'h2, 8'h33, 1'b1);
        rd(4'hF);
        chk("pushpop_status", 64'(rd_data), 64'hB1);

        // Mode write/read collision returns the old value; new value next cycle.
        wr(4'h0, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 4'h0, 8'h33, 1'b1, 4'h0, 1'b0, 1'b0);
        chk("mode_old_read", 64'(rd_data), 64'h5A);
        chk("mode_new", 64'(mode), 64'h33);

        // Reset mid-stream with a partial command pending.
        wr(4'h1, 8'h00, 1'b0);
        wr(4'h2, 8'h11, 1'b0);
        step(1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0, 1'b0);
        chk("midrst_valid", 64'(cmd_valid), 64'h0);
        chk("midrst_opcode", 64'(cmd_opcode), 64'h0);
        chk("midrst_mode", 64'(mode), 64'h0);
        rd(4'hF);
        chk("midrst_status", 64'(rd_data), 64'h80);

        // Random traffic against the model.
        thr = 90;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) thr = (thr == 90) ? 10 : 90;
            we = 1'b1; wa = 4'h0; wd = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1: begin
                    wa = 4'h1;
                    case ($urandom_range(0, 4))
                        0: wd = 8'h00;
                        1: wd = 8'h01;
                        2: wd = 8'h02;
                        3: wd = 8'h10;
                        default: wd = 8'($urandom);
                    endcase
                end
                2, 3, 4, 5: wa = 4'($urandom_range(2, 5));
                6: wa = 4'h0;
                7: wa = 4'hF;
                8: wa = 4'($urandom_range(0, 15));
                default: we = 1'b0;
            endcase
            re = ($urandom_range(0, 1) == 1);
            ra = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            rdy = ($urandom_range(0, 99) < thr);
            eb = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step(rst, we, wa, wd, re, ra, rdy, eb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
